// File: rtl/sat_ctr_bank.sv
// ---------------------------------------------------------------------------
// sat_ctr_bank
//
// Bank of NCH independent counters used for event/credit tracking. Each
// channel counts in 0..MAX_VAL. At the limits a channel either saturates
// (WRAP=0) or wraps modulo MAX_VAL+1 (WRAP=1). Each channel also keeps a
// sticky error flag that records out-of-range attempts.
//
// Parameters:
//   NCH      number of channels (>= 1)
//   WIDTH    count width per channel in bits (>= 1)
//   MAX_VAL  terminal value, 1 <= MAX_VAL <= 2^WIDTH-1
//   WRAP     0 = saturate at the limits, 1 = wrap modulo MAX_VAL+1
//
// Ports:
//   clk      clock; all state updates on the rising edge
//   rst      synchronous reset, active-low; overrides every other input
//   ctr_rst  per-channel synchronous clear of the count (err is kept)
//   inc      per-channel increment request
//   dec      per-channel decrement request (inc and dec together = hold)
//   ld       per-channel parallel load request
//   ld_val   load values; channel i uses ld_val[i*WIDTH +: WIDTH]
//   err_clr  clears every sticky err bit (a same-cycle new error wins)
//   out      registered counts; channel i in out[i*WIDTH +: WIDTH]
//   at_max   out[i] == MAX_VAL, decoded from the register
//   at_zero  out[i] == 0, decoded from the register
//   err      sticky per-channel error flag
//
// Channel priority, highest first:
//   rst > ctr_rst > illegal-state recovery > ld > inc/dec.
// ---------------------------------------------------------------------------
module sat_ctr_bank #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 5,
  parameter int WRAP    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         ctr_rst,
  input  logic [NCH-1:0]         inc,
  input  logic [NCH-1:0]         dec,
  input  logic [NCH-1:0]         ld,
  input  logic [NCH*WIDTH-1:0]   ld_val,
  input  logic                   err_clr,
  output logic [NCH*WIDTH-1:0]   out,
  output logic [NCH-1:0]         at_max,
  output logic [NCH-1:0]         at_zero,
  output logic [NCH-1:0]         err
);

  // The "greater than MAX_VAL" tests are done one bit wider than the count.
  // When MAX_VAL is the all-ones value of WIDTH bits, the comparisons stay
  // well formed and simply never fire.
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam bit               WRAP_EN = (WRAP != 0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] ld_v;
    logic             illegal;
    logic             ld_over;
    logic             err_evt;

    assign ld_v    = ld_val[i*WIDTH +: WIDTH];
    assign illegal = {1'b0, cnt_q} > MAX_EXT;
    assign ld_over = {1'b0, ld_v} > MAX_EXT;

    // Next-count selection in priority order. err_evt marks any
    // out-of-range attempt seen this cycle.
    always_comb begin
      cnt_d   = cnt_q;
      err_evt = 1'b0;
      if (ctr_rst[i]) begin
        cnt_d = '0;
      end else if (illegal) begin
        // A count above MAX_VAL cannot occur in normal operation. If one
        // ever appears (for example from an upset), recover to zero and
        // flag it.
        cnt_d   = '0;
        err_evt = 1'b1;
      end else if (ld[i]) begin
        if (ld_over) begin
          cnt_d   = MAX_W;
          err_evt = 1'b1;
        end else begin
          cnt_d = ld_v;
        end
      end else if (inc[i] && !dec[i]) begin
        if (cnt_q == MAX_W) begin
          if (WRAP_EN) begin
            cnt_d = '0;
          end else begin
            err_evt = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q == '0) begin
          if (WRAP_EN) begin
            cnt_d = MAX_W;
          end else begin
            err_evt = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
    end

    // Sticky error: a new event on this channel beats a same-cycle err_clr.
    always_comb begin
      err_d = err_evt | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign out[i*WIDTH +: WIDTH] = cnt_q;
    assign at_max[i]             = (cnt_q == MAX_W);
    assign at_zero[i]            = (cnt_q == '0);
    assign err[i]                = err_q;

  end : g_ch

endmodule
